// File: rtl/riscv_divider_pkg.sv
// Shared definitions for the M-extension divider: op encoding, FSM state
// type and a helper for the most-negative two's-complement constant.
package riscv_div_pkg;

  // Op encoding: bit 0 selects unsigned, bit 1 selects remainder.
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Widest supported operand width; helpers return values this wide.
  localparam int MAX_XLEN = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // 1 << (xlen-1) in a MAX_XLEN-wide vector; callers slice [xlen-1:0].
  function automatic logic [MAX_XLEN-1:0] most_neg(input int xlen);
    logic [MAX_XLEN-1:0] one;
    one = {{(MAX_XLEN-1){1'b0}}, 1'b1};
    return one << (xlen - 1);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/riscv_divider_if.sv
// Request/response bundle between the execute stage and the divider.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The request side (in_valid, op, dividend, divisor, tag_i)
// holds its payload stable while in_valid is high and in_ready is low; the
// divider holds out_valid, result and tag_o stable until out_ready is seen
// high on an edge. flush overrides both handshakes in the same cycle.
interface riscv_divider_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();

  localparam int CNT_W = $clog2(XLEN);

  logic                        in_valid;
  logic                        in_ready;
  logic [1:0]                  op;
  logic [XLEN-1:0]             dividend;
  logic [XLEN-1:0]             divisor;
  logic [TAG_W-1:0]            tag_i;
  logic                        flush;
  logic                        out_valid;
  logic                        out_ready;
  logic [XLEN-1:0]             result;
  logic [TAG_W-1:0]            tag_o;
  logic                        busy;
  // Debug visibility of the control FSM and iteration counter.
  riscv_div_pkg::div_state_e   dbg_state;
  logic [CNT_W-1:0]            dbg_count;

  // Execute stage / consumer side.
  modport master (
    output in_valid, op, dividend, divisor, tag_i, flush, out_ready,
    input  in_ready, out_valid, result, tag_o, busy, dbg_state, dbg_count
  );

  // Divider side.
  modport slave (
    input  in_valid, op, dividend, divisor, tag_i, flush, out_ready,
    output in_ready, out_valid, result, tag_o, busy, dbg_state, dbg_count
  );

endinterface

// File: rtl/riscv_divider_core.sv
// Unsigned restoring divider datapath, one quotient bit per cycle, MSB
// first. Operands are magnitudes; sign handling lives in the wrapper.
// done_o is asserted during the final iteration and quotient_o /
// remainder_o then carry the values that iteration produces, so the
// wrapper can register the final result on the same edge.
module div_core_unsigned #(
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [XLEN-1:0]          dividend_i,
  input  logic [XLEN-1:0]          divisor_i,
  output logic [$clog2(XLEN)-1:0]  count_o,
  output logic                     done_o,
  output logic [XLEN-1:0]          quotient_o,
  output logic [XLEN-1:0]          remainder_o
);

  localparam int CNT_W = $clog2(XLEN);

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  // Dividend bits shift out of the top while quotient bits shift in below.
  logic [XLEN-1:0]  dvd_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  dsr_q;

  logic [XLEN:0]    rem_shift;
  logic [XLEN:0]    diff;
  logic             no_borrow;
  logic             last_iter;
  logic [XLEN-1:0]  dvd_d;
  logic [XLEN-1:0]  rem_d;

  // One trial subtraction on the XLEN+1-bit partial remainder.
  always_comb begin
    rem_shift = {rem_q, dvd_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dsr_q};
    no_borrow = ~diff[XLEN];
    dvd_d     = {dvd_q[XLEN-2:0], no_borrow};
    // On a borrow the shifted remainder is below the divisor, so it fits.
    rem_d     = no_borrow ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    last_iter = run_q && (cnt_q == CNT_W'(XLEN - 1));
  end

  // Iteration state: load on start, step while running, stop after XLEN bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      dvd_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (abort_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      dvd_q <= dividend_i;
      rem_q <= '0;
      dsr_q <= divisor_i;
    end else if (run_q) begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      if (last_iter) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign count_o     = cnt_q;
  assign done_o      = last_iter;
  assign quotient_o  = dvd_d;
  assign remainder_o = rem_d;

endmodule

// File: rtl/riscv_divider.sv
// RISC-V M-extension divider (DIV/DIVU/REM/REMU). Handles operand signs,
// divide-by-zero and signed overflow, the request/response handshakes and
// flush; the unsigned iteration is delegated to div_core_unsigned.
module riscv_divider
  import riscv_div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic             clk,
  input logic             rst,
  riscv_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [MAX_XLEN-1:0] MOST_NEG_W = most_neg(XLEN);
  localparam logic [XLEN-1:0]     MOST_NEG   = MOST_NEG_W[XLEN-1:0];

  div_state_e        state_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   result_q;
  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  tag_o_q;
  logic              is_rem_q;
  logic              neg_q_q;
  logic              neg_r_q;

  logic              in_ready;
  logic              accept;
  logic              is_signed;
  logic              is_rem;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              div_zero;
  logic              sgn_ovf;
  logic              special;
  logic [XLEN-1:0]   special_res;

  logic              core_start;
  logic              core_done;
  logic [CNT_W-1:0]  core_count;
  logic [XLEN-1:0]   core_quot;
  logic [XLEN-1:0]   core_rem;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   calc_res_d;

  // Ready depends only on state and reset, never on in_valid.
  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Request decode: operand magnitudes and the two architectural corner cases.
  always_comb begin
    is_signed   = op_is_signed(bus.op);
    is_rem      = op_is_rem(bus.op);
    a_neg       = is_signed && bus.dividend[XLEN-1];
    b_neg       = is_signed && bus.divisor[XLEN-1];
    a_mag       = a_neg ? -bus.dividend : bus.dividend;
    b_mag       = b_neg ? -bus.divisor  : bus.divisor;
    div_zero    = (bus.divisor == '0);
    sgn_ovf     = is_signed && (bus.dividend == MOST_NEG) && (bus.divisor == '1);
    special     = div_zero || sgn_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = is_rem ? bus.dividend : '1;
    end else if (sgn_ovf) begin
      special_res = is_rem ? '0 : bus.dividend;
    end
  end

  assign core_start = accept && !special;

  div_core_unsigned #(
    .XLEN(XLEN)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .start_i    (core_start),
    .abort_i    (bus.flush),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .count_o    (core_count),
    .done_o     (core_done),
    .quotient_o (core_quot),
    .remainder_o(core_rem)
  );

  // Sign fixups on the core's final values, then quotient/remainder select.
  always_comb begin
    quot_fix   = neg_q_q ? -core_quot : core_quot;
    rem_fix    = neg_r_q ? -core_rem  : core_rem;
    calc_res_d = is_rem_q ? rem_fix : quot_fix;
  end

  // Control FSM with registered result, tag and out_valid; flush wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      tag_o_q     <= '0;
      is_rem_q    <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tag_q    <= bus.tag_i;
            is_rem_q <= is_rem;
            neg_q_q  <= is_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
            neg_r_q  <= a_neg;
            if (special) begin
              result_q    <= special_res;
              tag_o_q     <= bus.tag_i;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (core_done) begin
            result_q    <= calc_res_d;
            tag_o_q     <= tag_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.tag_o     = tag_o_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.dbg_state = state_q;
  assign bus.dbg_count = core_count;

endmodule

// File: tb/tb_riscv_divider.sv
// Self-checking bench for riscv_divider (XLEN=32): directed corner cases,
// backpressure, flush, mid-operation reset and randomized traffic against a
// plain-arithmetic reference model.
module tb_riscv_divider;
  import riscv_div_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_divider_if #(.XLEN(XLEN), .TAG_W(TAG_W)) dif ();

  riscv_divider #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif.slave)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [XLEN-1:0]  exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: architectural RISC-V semantics with 64-bit arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [31:0]     r;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      2'b01:   r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      2'b10:   r = (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: r = (b == 0) ? a : 32'(ua % ub);
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Compare process: every cycle a result is presented it must match the
  // head of the expected queue; it is retired when out_ready is also high.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && dif.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        check("result", dif.result, exp_q[0]);
        check("tag_o", dif.tag_o, exp_tag_q[0]);
        check("in_ready_while_done", dif.in_ready, 64'd0);
        check("busy_while_done", dif.busy, 64'd1);
        if (dif.out_ready === 1'b1) begin
          void'(exp_q.pop_front());
          void'(exp_tag_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int w;
    w = 0;
    while (dif.in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("in_ready_timeout", 64'd0, 64'd1);
  endtask

  // Issue one request, check latency, hold backpressure for bp cycles, retire.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp, input int bp);
    int lat;
    wait_ready();
    exp_q.push_back(exp);
    exp_tag_q.push_back(tag);
    dif.in_valid = 1'b1;
    dif.op       = op;
    dif.dividend = a;
    dif.divisor  = b;
    dif.tag_i    = tag;
    @(posedge clk);
    @(negedge clk);
    dif.in_valid = 1'b0;
    dif.dividend = $urandom;
    dif.divisor  = $urandom;
    lat = 1;
    while (dif.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, is_special(op, a, b) ? 64'd1 : 64'(XLEN + 1));
    if (lat >= 100) begin
      exp_q.delete();
      exp_tag_q.delete();
      return;
    end
    repeat (bp) @(negedge clk);
    dif.out_ready = 1'b1;
    @(negedge clk);
    dif.out_ready = 1'b0;
    check("in_ready_after_handshake", dif.in_ready, 64'd1);
  endtask

  // Directed op: pin the model against a hand-computed value, then run it.
  task automatic directed(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic [31:0] lit, input int bp);
    check("model_pin", ref_div(op, a, b), lit);
    run_op(op, a, b, tag, lit, bp);
  endtask

  // Start an op that will be abandoned; returns after the acceptance edge.
  task automatic start_discarded(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [TAG_W-1:0] tag);
    wait_ready();
    dif.in_valid = 1'b1;
    dif.op       = op;
    dif.dividend = a;
    dif.divisor  = b;
    dif.tag_i    = tag;
    @(posedge clk);
    @(negedge clk);
    dif.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand(input bit is_divisor);
    case ($urandom_range(0, 7))
      0:       return is_divisor ? 32'd0 : 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(1, 20));
      3:       return -32'($urandom_range(1, 20));
      4:       return $urandom >> $urandom_range(1, 30);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst           = 1'b1;
    dif.in_valid  = 1'b0;
    dif.op        = OP_DIV;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.tag_i     = '0;
    dif.flush     = 1'b0;
    dif.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", dif.in_ready, 64'd0);
    check("rst_out_valid", dif.out_valid, 64'd0);
    check("rst_result", dif.result, 64'd0);
    check("rst_tag_o", dif.tag_o, 64'd0);
    check("rst_busy", dif.busy, 64'd0);
    check("rst_state", dif.dbg_state, 64'(ST_IDLE));
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", dif.in_ready, 64'd1);
    @(negedge clk);

    // Signed/unsigned normal cases.
    directed(OP_DIV,  32'hFFFF_FFF9, 32'h2,          5'd1,  32'hFFFF_FFFD, 0);
    directed(OP_REM,  32'hFFFF_FFF9, 32'h2,          5'd2,  32'hFFFF_FFFF, 1);
    directed(OP_DIVU, 32'hFFFF_FFFF, 32'h1,          5'd3,  32'hFFFF_FFFF, 0);
    directed(OP_REMU, 32'd100,       32'd7,          5'd4,  32'd2,         0);
    directed(OP_REM,  32'd7,         32'hFFFF_FFFE,  5'd5,  32'd1,         0);
    // Divide-by-zero and signed overflow.
    directed(OP_DIV,  32'd5,         32'd0,          5'd6,  32'hFFFF_FFFF, 0);
    directed(OP_REMU, 32'd5,         32'd0,          5'd7,  32'd5,         0);
    directed(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  5'd8,  32'h8000_0000, 0);
    directed(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF,  5'd9,  32'd0,         0);
    // Unsigned op with the overflow pattern takes the normal path.
    directed(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,  5'd10, 32'd0,         0);
    // Backpressure: result held for 10 cycles, next op back-to-back.
    directed(OP_DIVU, 32'd1000,      32'd9,          5'd11, 32'd111,       10);
    directed(OP_DIV,  32'hFFFF_FF9C, 32'd0,          5'd12, 32'hFFFF_FFFF, 10);
    directed(OP_REMU, 32'd1000,      32'd9,          5'd13, 32'd1,         0);

    // Flush 10 cycles into CALC: nothing delivered, ready next cycle.
    start_discarded(OP_DIV, 32'd100, 32'd7, 5'd20);
    repeat (9) @(negedge clk);
    check("busy_in_calc", dif.busy, 64'd1);
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    check("flush_in_ready", dif.in_ready, 64'd1);
    check("flush_out_valid", dif.out_valid, 64'd0);
    check("flush_busy", dif.busy, 64'd0);
    repeat (40) @(negedge clk);
    directed(OP_DIV, 32'd9, 32'd3, 5'd21, 32'd3, 0);

    // Reset pulsed mid-CALC: outputs at reset values without a clock edge.
    start_discarded(OP_DIVU, 32'd12345, 32'd17, 5'd22);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", dif.out_valid, 64'd0);
    check("midrst_result", dif.result, 64'd0);
    check("midrst_tag_o", dif.tag_o, 64'd0);
    check("midrst_busy", dif.busy, 64'd0);
    check("midrst_in_ready", dif.in_ready, 64'd0);
    check("midrst_state", dif.dbg_state, 64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    directed(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd23, 32'hFFFF_FFFE, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]       r_op;
      logic [31:0]      r_a;
      logic [31:0]      r_b;
      logic [TAG_W-1:0] r_tag;
      r_op  = 2'($urandom_range(0, 3));
      r_a   = rand_operand(1'b0);
      r_b   = rand_operand(1'b1);
      r_tag = TAG_W'($urandom);
      run_op(r_op, r_a, r_b, r_tag, ref_div(r_op, r_a, r_b), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_divider.md
# riscv_divider

Parametrised iterative integer divider for the RISC-V M-extension execute stage. It implements DIV, DIVU, REM and REMU at width XLEN with a one-bit-per-cycle restoring algorithm. It has valid/ready handshakes on both sides, a destination tag, pipeline flush, and architecturally-correct results for divide-by-zero and signed overflow. It sits beside the ALU and is shared by all M-extension divide ops.

## Interface
- XLEN, 32, operand/result width; legal values 32 or 64.
- TAG_W, 5, width of the pass-through tag (rd index).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  divider can accept; high only in IDLE.
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  XLEN  rs1 value.
- divisor  in  XLEN  rs2 value.
- tag_i  in  TAG_W  tag captured with the request.
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).
- tag_o  out  TAG_W  tag of the result.
- busy  out  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC on in_valid & in_ready & ~flush. Latch op, tag, and operand magnitudes. Latch the quotient-negate flag (signed & sign mismatch) and the remainder-negate flag (signed & dividend negative). Clear the count.
- IDLE -> DONE directly (special case) on acceptance when:
  - divisor == 0: quotient = all ones; remainder = dividend.
  - signed op with dividend == 1<<(XLEN-1) and divisor == all ones: quotient = dividend; remainder = 0.
- CALC: each cycle shift the partial remainder (XLEN+1 bits) left by one and bring in the next dividend bit, MSB first. Trial-subtract the divisor magnitude. If there is no borrow, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0. After XLEN iterations the count reaches XLEN-1 and the state moves to DONE.
- On entering DONE, apply the latched sign fixups (two's complement) and select the quotient or remainder by op. result and tag_o are registered.
- DONE: out_valid high. result and tag_o stay stable until out_ready. Then go to IDLE.
- flush: in any state, go to IDLE on the next edge. out_valid drops and no result is delivered. flush has priority over in_valid and out_ready in the same cycle.
- Unsigned ops ignore operand sign bits entirely.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, tag_o 0, busy 0. in_ready is 0 while rst is asserted and 1 after it is released.
- Normal latency: acceptance edge at T, out_valid high at T+XLEN+1 (33 cycles for XLEN=32).
- Special-case latency: out_valid high at T+1.
- Throughput: one op per XLEN+2 cycles at best. in_ready is low from the acceptance edge until DONE exits.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Asynchronous reset mid-operation: the result is discarded and all outputs take their reset values immediately.
- Count register width is $clog2(XLEN). Partial remainder is XLEN+1 bits so the trial subtraction never overflows.

## Structure
- Package riscv_div_pkg holds:
  - the op encoding (DIV/DIVU/REM/REMU constants);
  - the state typedef;
  - a helper that returns the XLEN-wide most-negative constant.
- Natural sub-module: div_core_unsigned, the unsigned shift/subtract datapath (start, count, done, quotient, remainder).
- Sign handling, special-case detection, handshake and FSM stay in riscv_divider.

## Test plan
- DIV -7 / 2 (0xFFFFFFF9, 0x2) -> result 0xFFFFFFFD, out_valid exactly 33 cycles after acceptance. REM with the same operands -> 0xFFFFFFFF.
- DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF. REMU 100 / 7 -> 2. REM 7 / -2 -> 1.
- Divide-by-zero:
  - DIV 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - out_valid at acceptance+1 with tag_o equal to tag_i.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0. Both at acceptance+1.
- Backpressure: hold out_ready low for 10 cycles in DONE.
  - result, tag_o and out_valid stay stable; in_ready stays 0.
  - The next request is accepted the cycle after the out_ready handshake.
- Flush and reset:
  - flush asserted 10 cycles into CALC -> out_valid never asserts, in_ready is 1 on the next cycle, and a following DIV 9/3 returns 3.
  - rst pulsed mid-CALC -> outputs at reset values immediately.
